// File: rtl/instcycle_ctrl.sv
// Multi-cycle instruction sequencer for the single-issue RV64 core.
// Steps an instruction through IF_REQ, IF_WAIT, IF_LATCH, ID, EX, (MEM), WB.
// It stalls on the fetch and data-memory handshakes, can be halted, and
// aborts a wait step that never completes.
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   start             leave IDLE and begin fetching (ignored outside IDLE)
//   halt_req          stop after the current instruction commits
//   if_ready          fetch handshake, sampled only in IF_WAIT
//   mem_req           instruction needs a data access, sampled in EX
//   mem_ready         data access complete, sampled only in MEM
//   instcycle_cnt_val current step number (0..7), decoded by every stage
//   if_en/mem_en/wb_en  per-step enables
//   inst_commit       one-cycle pulse while in WB
//   inst_count        committed-instruction counter (wraps)
//   halted            parked in IDLE after a halt or a memory timeout
//   timeout_err       one-cycle pulse on any wait timeout
module instcycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic [7:0]  instcycle_cnt_val,
  output logic        if_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        inst_commit,
  output logic [63:0] inst_count,
  output logic        halted,
  output logic        timeout_err
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned CNT_W  = 64;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_IF_REQ   = 3'd1,
    S_IF_WAIT  = 3'd2,
    S_IF_LATCH = 3'd3,
    S_ID       = 3'd4,
    S_EX       = 3'd5,
    S_MEM      = 3'd6,
    S_WB       = 3'd7
  } step_e;

  step_e              step_q, step_d;
  logic [WAIT_W-1:0]  wait_cnt, wait_d;
  logic               halt_pend, halt_pend_d;
  logic               halted_d;
  logic               tmo_d;
  logic [CNT_W-1:0]   count_d;

  assign instcycle_cnt_val = 8'(step_q);

  // State and registered outputs; enables follow the next step so they
  // line up with the step they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q      <= S_IDLE;
      wait_cnt    <= '0;
      halt_pend   <= 1'b0;
      halted      <= 1'b0;
      timeout_err <= 1'b0;
      inst_count  <= '0;
      if_en       <= 1'b0;
      mem_en      <= 1'b0;
      wb_en       <= 1'b0;
      inst_commit <= 1'b0;
    end else begin
      step_q      <= step_d;
      wait_cnt    <= wait_d;
      halt_pend   <= halt_pend_d;
      halted      <= halted_d;
      timeout_err <= tmo_d;
      inst_count  <= count_d;
      if_en       <= (step_d == S_IF_REQ);
      mem_en      <= (step_d == S_MEM);
      wb_en       <= (step_d == S_WB);
      inst_commit <= (step_d == S_WB);
    end
  end

  // Next-step logic.
  always_comb begin
    step_d      = step_q;
    wait_d      = wait_cnt;
    halt_pend_d = halt_pend;
    halted_d    = halted;
    tmo_d       = 1'b0;
    count_d     = inst_count;

    // A halt request seen in WB itself still stops after this commit.
    if ((step_q != S_IDLE) && halt_req) halt_pend_d = 1'b1;

    unique case (step_q)
      S_IDLE: begin
        if (start) begin
          step_d   = S_IF_REQ;
          halted_d = 1'b0;
        end
      end
      S_IF_REQ: begin
        step_d = S_IF_WAIT;
        wait_d = '0;
      end
      S_IF_WAIT: begin
        // Ready beats a coincident timeout.
        if (if_ready) begin
          step_d = S_IF_LATCH;
        end else if (wait_cnt == WAIT_LAST) begin
          step_d = S_IF_REQ;
          tmo_d  = 1'b1;
        end else begin
          wait_d = wait_cnt + WAIT_W'(1);
        end
      end
      S_IF_LATCH: step_d = S_ID;
      S_ID:       step_d = S_EX;
      S_EX: begin
        if (mem_req) begin
          step_d = S_MEM;
          wait_d = '0;
        end else begin
          step_d = S_WB;
        end
      end
      S_MEM: begin
        // A stuck data access is fatal: park in IDLE without committing.
        if (mem_ready) begin
          step_d = S_WB;
        end else if (wait_cnt == WAIT_LAST) begin
          step_d   = S_IDLE;
          halted_d = 1'b1;
          tmo_d    = 1'b1;
        end else begin
          wait_d = wait_cnt + WAIT_W'(1);
        end
      end
      S_WB: begin
        if (halt_pend_d) begin
          step_d   = S_IDLE;
          halted_d = 1'b1;
        end else begin
          step_d = S_IF_REQ;
        end
      end
      default: step_d = S_IDLE;
    endcase

    if (step_d == S_WB) count_d = inst_count + CNT_W'(1);
    if (step_d == S_IDLE) halt_pend_d = 1'b0;
  end

endmodule

// File: tb/tb_instcycle_ctrl.sv
// Self-checking bench for instcycle_ctrl: dut_a uses the default timeout,
// dut_b a timeout of 4 cycles. Both share the stimulus inputs.
module tb_instcycle_ctrl;

  logic clk = 1'b0;
  logic rst, start, halt_req, if_ready, mem_req, mem_ready;

  logic [7:0]  a_step, b_step;
  logic        a_if_en, a_mem_en, a_wb_en, a_commit, a_halted, a_tmo;
  logic        b_if_en, b_mem_en, b_wb_en, b_commit, b_halted, b_tmo;
  logic [63:0] a_count, b_count;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [7:0] step;
    logic       tmo;
    logic       halted;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  instcycle_ctrl #(.TIMEOUT_CYCLES(255)) dut_a (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .if_ready(if_ready), .mem_req(mem_req), .mem_ready(mem_ready),
    .instcycle_cnt_val(a_step), .if_en(a_if_en), .mem_en(a_mem_en),
    .wb_en(a_wb_en), .inst_commit(a_commit), .inst_count(a_count),
    .halted(a_halted), .timeout_err(a_tmo)
  );

  instcycle_ctrl #(.TIMEOUT_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .if_ready(if_ready), .mem_req(mem_req), .mem_ready(mem_ready),
    .instcycle_cnt_val(b_step), .if_en(b_if_en), .mem_en(b_mem_en),
    .wb_en(b_wb_en), .inst_commit(b_commit), .inst_count(b_count),
    .halted(b_halted), .timeout_err(b_tmo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] obs_vec(input logic use_b);
    if (use_b) return {b_step, b_if_en, b_mem_en, b_wb_en, b_commit, b_tmo, b_halted};
    return {a_step, a_if_en, a_mem_en, a_wb_en, a_commit, a_tmo, a_halted};
  endfunction

  // Reference decode of the per-step outputs from the expected step.
  function automatic logic [13:0] exp_vec(input exp_t e);
    return {e.step, (e.step == 8'd1), (e.step == 8'd6), (e.step == 8'd7),
            (e.step == 8'd7), e.tmo, e.halted};
  endfunction

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; halt_req = 1'b0;
    if_ready = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (obs_vec(1'b0) !== 14'd0) $display("FAIL reset_a got %h want %h", obs_vec(1'b0), 14'd0);
    else passed++;
    total++;
    if (obs_vec(1'b1) !== 14'd0) $display("FAIL reset_b got %h want %h", obs_vec(1'b1), 14'd0);
    else passed++;
    total++;
    if ({a_count, b_count} !== 128'd0) $display("FAIL reset_count got %h/%h want 0", a_count, b_count);
    else passed++;
    tick();
    total++;
    if (a_step !== 8'd0) $display("FAIL idle_hold got %0d want 0", a_step);
    else passed++;
  endtask

  task automatic test_basic_loop();
    int pat[6] = '{1, 2, 3, 4, 5, 7};
    exp_t e;
    apply_reset();
    start = 1'b1; if_ready = 1'b1; mem_req = 1'b0;
    for (int i = 0; i < 18; i++) sb.push_back(exp_t'{8'(pat[i % 6]), 1'b0, 1'b0});
    for (int i = 0; i < 18; i++) begin
      tick();
      e = sb.pop_front();
      total++;
      if (obs_vec(1'b0) !== exp_vec(e))
        $display("FAIL basic[%0d] got %h want %h", i, obs_vec(1'b0), exp_vec(e));
      else passed++;
      start = 1'b0;
    end
    total++;
    if (a_count !== 64'd3) $display("FAIL basic_count got %0d want 3", a_count);
    else passed++;
  endtask

  task automatic test_mem_access();
    int seq[12] = '{1, 2, 3, 4, 5, 6, 6, 6, 6, 6, 7, 1};
    exp_t e;
    apply_reset();
    start = 1'b1; if_ready = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    foreach (seq[i]) sb.push_back(exp_t'{8'(seq[i]), 1'b0, 1'b0});
    for (int i = 0; i < 12; i++) begin
      tick();
      e = sb.pop_front();
      total++;
      if (obs_vec(1'b0) !== exp_vec(e))
        $display("FAIL mem[%0d] got %h want %h", i, obs_vec(1'b0), exp_vec(e));
      else passed++;
      start = 1'b0;
      mem_ready = (i == 9);
    end
    total++;
    if (a_count !== 64'd1) $display("FAIL mem_count got %0d want 1", a_count);
    else passed++;
  endtask

  task automatic test_fetch_timeout();
    int seq[14] = '{1, 2, 2, 2, 2, 1, 2, 2, 2, 2, 3, 4, 5, 7};
    exp_t e;
    apply_reset();
    start = 1'b1; if_ready = 1'b0; mem_req = 1'b0;
    foreach (seq[i]) sb.push_back(exp_t'{8'(seq[i]), (i == 5), 1'b0});
    for (int i = 0; i < 14; i++) begin
      tick();
      e = sb.pop_front();
      total++;
      if (obs_vec(1'b1) !== exp_vec(e))
        $display("FAIL ftmo[%0d] got %h want %h", i, obs_vec(1'b1), exp_vec(e));
      else passed++;
      if (i == 5) begin
        total++;
        if (b_count !== 64'd0) $display("FAIL ftmo_nocommit got %0d want 0", b_count);
        else passed++;
      end
      start = 1'b0;
      // Ready arrives on the last allowed wait cycle: it must win.
      if (i == 9) if_ready = 1'b1;
    end
    total++;
    if (b_count !== 64'd1) $display("FAIL ftmo_count got %0d want 1", b_count);
    else passed++;
  endtask

  task automatic test_mem_timeout();
    int seq[11] = '{1, 2, 3, 4, 5, 6, 6, 6, 6, 0, 0};
    exp_t e;
    apply_reset();
    start = 1'b1; if_ready = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    foreach (seq[i]) sb.push_back(exp_t'{8'(seq[i]), (i == 9), (i >= 9)});
    for (int i = 0; i < 11; i++) begin
      tick();
      e = sb.pop_front();
      total++;
      if (obs_vec(1'b1) !== exp_vec(e))
        $display("FAIL mtmo[%0d] got %h want %h", i, obs_vec(1'b1), exp_vec(e));
      else passed++;
      start = 1'b0;
      // mem_ready outside step 6 must be ignored.
      mem_ready = (i >= 1) && (i <= 3);
    end
    total++;
    if (b_count !== 64'd0) $display("FAIL mtmo_count got %0d want 0", b_count);
    else passed++;
  endtask

  task automatic test_halt();
    int seq[15] = '{1, 2, 3, 4, 5, 7, 0, 0, 1, 2, 3, 4, 5, 7, 1};
    exp_t e;
    apply_reset();
    start = 1'b1; if_ready = 1'b1; mem_req = 1'b0;
    foreach (seq[i]) sb.push_back(exp_t'{8'(seq[i]), 1'b0, (i == 6) || (i == 7)});
    for (int i = 0; i < 15; i++) begin
      tick();
      e = sb.pop_front();
      total++;
      if (obs_vec(1'b0) !== exp_vec(e))
        $display("FAIL halt[%0d] got %h want %h", i, obs_vec(1'b0), exp_vec(e));
      else passed++;
      // Pulse in step 4 halts; pulse in IDLE is ignored.
      halt_req = (i == 3) || (i == 6);
      start = (i == 7);
    end
    total++;
    if (a_count !== 64'd2) $display("FAIL halt_count got %0d want 2", a_count);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int seq[17] = '{1, 2, 3, 4, 5, 7, 1, 2, 3, 4, 5, 6, 0, 0, 1, 2, 2};
    exp_t e;
    apply_reset();
    start = 1'b1; if_ready = 1'b1; mem_req = 1'b0; mem_ready = 1'b0;
    foreach (seq[i]) sb.push_back(exp_t'{8'(seq[i]), 1'b0, 1'b0});
    for (int i = 0; i < 17; i++) begin
      tick();
      e = sb.pop_front();
      total++;
      if (obs_vec(1'b0) !== exp_vec(e))
        $display("FAIL rstmid[%0d] got %h want %h", i, obs_vec(1'b0), exp_vec(e));
      else passed++;
      if (i == 11) begin
        total++;
        if (a_count !== 64'd1) $display("FAIL rstmid_pre got %0d want 1", a_count);
        else passed++;
      end
      if (i == 12) begin
        total++;
        if (a_count !== 64'd0) $display("FAIL rstmid_count got %0d want 0", a_count);
        else passed++;
      end
      start    = (i == 13);
      mem_req  = (i >= 6);
      rst      = (i == 11);
      // if_ready is high during step 1 (i == 14) and must not skip step 2.
      if_ready = (i <= 12) || (i == 14);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_loop();
    test_mem_access();
    test_fetch_timeout();
    test_mem_timeout();
    test_halt();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
